// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial signed adder sequencer.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_full_adder.sv
// One-bit full adder: the only arithmetic in the serial datapath.
// Purely combinational; the caller registers the carry between bits.
module serial_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic axb;

    assign axb  = a ^ b;
    assign s    = axb ^ cin;
    assign cout = (a & b) | (axb & cin);

endmodule

// File: rtl/serial_signed_add_ctrl.sv
// Bit-serial two's-complement adder: one operand bit per cycle, LSB first.
// Result valid WIDTH cycles after accept; out_ready low in DONE holds the result.
module serial_signed_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             overflow,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_signed_add_ctrl: WIDTH out of legal range");
    end

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic             ovf_r;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_cout;
    logic             last_bit;

    serial_full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            sum_r <= '0;
            carry <= 1'b0;
            ovf_r <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Sum bits enter at the MSB so bit 0 lands in sum[0] after WIDTH shifts.
                    sum_r <= {fa_s, sum_r[WIDTH-1:1]};
                    carry <= fa_cout;
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        // carry holds the carry into the MSB; fa_cout is the one out of it.
                        ovf_r <= carry ^ fa_cout;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);
    assign sum       = sum_r;
    assign overflow  = ovf_r;

endmodule

// File: doc/serial_signed_add_ctrl.md
Name: serial_signed_add_ctrl

Overview:
Sequencer for a bit-serial two's-complement adder. It accepts a pair of WIDTH-bit signed operands through a valid/ready handshake and feeds them LSB-first through a single 1-bit full adder, one bit per cycle, with a registered carry. It assembles the sum and flags signed overflow, then presents the result through an output valid/ready handshake. It sits between an operand producer and a result consumer and trades throughput for a minimal adder area.

Parameters:
WIDTH, 4, operand/sum width in bits; legal range 2..32.

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operand pair a/b valid
in_ready  output  1  block can accept operands
a  input  WIDTH  signed operand A (two's complement)
b  input  WIDTH  signed operand B (two's complement)
out_valid  output  1  sum/overflow valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  a+b modulo 2^WIDTH
overflow  output  1  signed overflow of a+b
busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, overflow=0, carry=0, bit counter=0, operand shift registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&in_ready at an edge: latch a and b into shift registers, clear carry and counter, go to RUN.
  - Operands are ignored while in_ready=0.
- RUN:
  - in_ready=0, busy=1.
  - Each edge processes bit i=counter: full adder inputs a_sr[0], b_sr[0], carry.
  - Sum bit shifts into the result register MSB-first-in (right shift), so after WIDTH edges bit 0 is in sum[0].
  - Carry register takes carry-out. Operand registers shift right. Counter increments.
  - On the edge processing bit WIDTH-1: overflow = carry_in_to_msb XOR carry_out_of_msb, registered. Go to DONE.
  - Carry-out of the MSB is discarded (modulo arithmetic).
- DONE:
  - out_valid=1; sum and overflow stable.
  - Hold until out_valid&out_ready at an edge, then go to IDLE with out_valid=0.
  - No new operand is accepted in DONE (in_ready=0), so the earliest next acceptance is the edge after the output handshake.
- Latency: out_valid rises exactly WIDTH cycles after the input-handshake edge.
- Throughput: one result per WIDTH+2 cycles when out_ready is held at 1.
- sum/overflow outputs: registered. They keep their last value after leaving DONE and are only meaningful while out_valid=1.
- Backpressure: out_ready low in DONE holds state indefinitely; no loss or corruption of sum/overflow.
- out_ready is don't-care outside DONE.
- Reset mid-RUN or mid-DONE: immediately return to reset values; the in-flight operation is discarded and no out_valid pulse follows.
- Equal operands, zero operands, and most-negative values require no special cases.
- Counter width: $clog2(WIDTH).

Decomposition:
- Shared package serial_add_pkg: enum state_t {IDLE, RUN, DONE}; localparam for the legal WIDTH bounds.
- Sub-module serial_full_adder (inputs a, b, cin; outputs s, cout):
  - Built from ^, &, | only.
  - Instantiated once; the controller owns the carry register.

Test Plan (WIDTH=4):
- a=3 (0011), b=4 (0100), out_ready=1 -> out_valid 4 cycles after accept; sum=0111 (7), overflow=0.
- a=7, b=1 -> sum=1000 (-8), overflow=1. Then a=-8 (1000), b=-1 (1111) -> sum=0111, overflow=1.
- a=-3 (1101), b=2 (0010) -> sum=1111 (-1), overflow=0. Then a=-4, b=-4 -> sum=1000, overflow=0.
- out_ready=0 for 10 cycles after out_valid -> out_valid, sum and overflow held stable; in_ready=0 throughout. out_ready=1 -> IDLE next cycle, in_ready=1.
- in_valid pulses while RUN (a=5, b=5) -> ignored; the result matches the original accepted operands.
- Assert rst asynchronously mid-RUN (after 2 bits) -> outputs go immediately to reset values, no out_valid. A fresh accept of a=1, b=1 yields sum=0010, overflow=0.
